// File: rtl/seg7_scan_mux.sv
`timescale 1ns/1ps
// seg7_scan_mux
//   Scans a DIGITS-wide hex value onto a common-anode seven-segment display.
//   The divided clock i_Scan_Clk is treated as asynchronous data: it is
//   synchronised, and each rising edge forms a one-cycle scan tick that
//   advances the displayed digit. New values are staged through a
//   load/pending handshake and committed only at frame boundaries, so a
//   frame never mixes old and new digits.
//
//   Optional feature: define SEG7_BLANK_LEADING_ZERO_EN to blank leading
//   zero digits (digit 0 is never blanked).
//
// Ports
//   i_Clk        system clock (only clock)
//   Reset_n      asynchronous active-low reset
//   i_Scan_Clk   divided scan clock, asynchronous data
//   i_Digits     4*DIGITS value, nibble k = digit k (digit 0 rightmost)
//   i_Load       one-cycle strobe, stage i_Digits
//   o_Pending    staged value awaiting commit
//   o_Anode      active-low digit enables (one-hot-low)
//   o_Seg        active-low segments {g,f,e,d,c,b,a}
//   o_Digit_Idx  index of the digit being driven

// Per-digit hex decoder, active-low gfedcba, with optional forced blank.
module seg7_digit_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (nib)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        default: seg = 7'h0E;
      endcase
    end
  end
endmodule

module seg7_scan_mux #(
  parameter int DIGITS    = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                  i_Clk,
  input  logic                  Reset_n,
  input  logic                  i_Scan_Clk,
  input  logic [4*DIGITS-1:0]   i_Digits,
  input  logic                  i_Load,
  output logic                  o_Pending,
  output logic [DIGITS-1:0]     o_Anode,
  output logic [6:0]            o_Seg,
  output logic [IDX_WIDTH-1:0]  o_Digit_Idx
);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t                     state;
  logic                       s1, s2, s3;
  logic                       tick, wrap, boundary;
  logic [IDX_WIDTH-1:0]       idx, idx_nxt;
  logic [DIGITS-1:0][3:0]     shadow, staged, shadow_nxt;
  logic                       pending;
  logic [DIGITS-1:0]          blank;
  logic [DIGITS-1:0][6:0]     dec_seg;

  // Rising edge of the synchronised scan clock; falling edges are ignored.
  assign tick = s2 & ~s3;

  always_comb begin
    wrap     = (idx == IDX_WIDTH'(DIGITS-1));
    // The first BLANK->SCAN tick starts a frame, as does every wrap.
    boundary = tick & ((state == BLANK) | wrap);
    idx_nxt  = idx;
    if (tick && state == SCAN)
      idx_nxt = wrap ? '0 : idx + IDX_WIDTH'(1);
    // Decode from the post-commit shadow so digit 0 of a new frame
    // already shows the new value.
    shadow_nxt = (boundary && pending) ? staged : shadow;
  end

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  // lz[k]: nibble k and everything above it are zero.
  logic [DIGITS:1] lz;
  assign lz[DIGITS] = 1'b1;
  assign blank[0]   = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_lz
    assign lz[k]    = (shadow_nxt[k] == 4'h0) & lz[k+1];
    assign blank[k] = lz[k];
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    seg7_digit_dec u_dec (
      .nib   (shadow_nxt[k]),
      .blank (blank[k]),
      .seg   (dec_seg[k])
    );
  end

  assign o_Pending = pending;

  always_ff @(posedge i_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      idx         <= '0;
      shadow      <= '0;
      staged      <= '0;
      pending     <= 1'b0;
      state       <= BLANK;
      o_Anode     <= '1;
      o_Seg       <= 7'h7F;
      o_Digit_Idx <= '0;
    end else begin
      s1 <= i_Scan_Clk;
      s2 <= s1;
      s3 <= s2;

      shadow <= shadow_nxt;

      // A load in the commit cycle restages and keeps pending set; the
      // commit itself used the old staged value above.
      if (i_Load) begin
        staged  <= i_Digits;
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end

      case (state)
        BLANK: begin
          if (tick) begin
            state       <= SCAN;
            idx         <= idx_nxt;
            o_Anode     <= ~(DIGITS'(1) << idx_nxt);
            o_Seg       <= dec_seg[idx_nxt];
            o_Digit_Idx <= idx_nxt;
          end
        end
        default: begin
          if (tick) begin
            idx         <= idx_nxt;
            o_Anode     <= ~(DIGITS'(1) << idx_nxt);
            o_Seg       <= dec_seg[idx_nxt];
            o_Digit_Idx <= idx_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
`timescale 1ns/1ps
// Directed bench for seg7_scan_mux (DIGITS=4).
module tb_seg7_scan_mux;

  logic        i_Clk;
  logic        Reset_n;
  logic        i_Scan_Clk;
  logic [15:0] i_Digits;
  logic        i_Load;
  logic        o_Pending;
  logic [3:0]  o_Anode;
  logic [6:0]  o_Seg;
  logic [1:0]  o_Digit_Idx;

  int checks = 0;
  int errors = 0;

  seg7_scan_mux #(.DIGITS(4), .IDX_WIDTH(2)) dut (
    .i_Clk       (i_Clk),
    .Reset_n     (Reset_n),
    .i_Scan_Clk  (i_Scan_Clk),
    .i_Digits    (i_Digits),
    .i_Load      (i_Load),
    .o_Pending   (o_Pending),
    .o_Anode     (o_Anode),
    .o_Seg       (o_Seg),
    .o_Digit_Idx (o_Digit_Idx)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [1:0] idx, input logic [6:0] seg,
                          input logic pend);
    logic [3:0] an;
    an = ~(4'b0001 << idx);
    chk({tag, ".idx"},   {30'd0, o_Digit_Idx}, {30'd0, idx});
    chk({tag, ".anode"}, {28'd0, o_Anode},     {28'd0, an});
    chk({tag, ".seg"},   {25'd0, o_Seg},       {25'd0, seg});
    chk({tag, ".pend"},  {31'd0, o_Pending},   {31'd0, pend});
  endtask

  // One scan clock period: rise, hold 3 cycles, fall, hold 3 cycles.
  // Outputs have updated by the third negedge after the rise.
  task automatic do_tick();
    i_Scan_Clk = 1'b1;
    repeat (3) @(negedge i_Clk);
    i_Scan_Clk = 1'b0;
    repeat (3) @(negedge i_Clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    i_Digits = v;
    i_Load   = 1'b1;
    @(negedge i_Clk);
    i_Load   = 1'b0;
  endtask

  logic [6:0] lz7;

  initial begin
    Reset_n    = 1'b0;
    i_Scan_Clk = 1'b0;
    i_Digits   = '0;
    i_Load     = 1'b0;

    // 1. reset holds blank while scan clock toggles
    for (int i = 0; i < 4; i++) begin
      i_Scan_Clk = ~i_Scan_Clk;
      repeat (3) @(negedge i_Clk);
      chk("rst.anode", {28'd0, o_Anode}, 32'hF);
      chk("rst.seg",   {25'd0, o_Seg},   32'h7F);
      chk("rst.pend",  {31'd0, o_Pending}, 32'h0);
    end
    i_Scan_Clk = 1'b0;
    repeat (3) @(negedge i_Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge i_Clk);
    chk("blank.anode", {28'd0, o_Anode}, 32'hF);
    // first rise: display after exactly 3 edges
    i_Scan_Clk = 1'b1;
    @(negedge i_Clk);
    chk("lat.e1", {28'd0, o_Anode}, 32'hF);
    @(negedge i_Clk);
    chk("lat.e2", {28'd0, o_Anode}, 32'hF);
    @(negedge i_Clk);
    chk_disp("lat.e3", 2'd0, 7'h40, 1'b0);
    i_Scan_Clk = 1'b0;
    repeat (3) @(negedge i_Clk);

    // 2. advance to idx 3, load 1234, scan a full frame
    do_tick(); do_tick(); do_tick();
    chk_disp("pre.i3", 2'd3, 7'h40, 1'b0);
    do_load(16'h1234);
    chk("t2.pend", {31'd0, o_Pending}, 32'h1);
    do_tick(); chk_disp("t2.i0", 2'd0, 7'h19, 1'b0);
    do_tick(); chk_disp("t2.i1", 2'd1, 7'h30, 1'b0);
    do_tick(); chk_disp("t2.i2", 2'd2, 7'h24, 1'b0);
    do_tick(); chk_disp("t2.i3", 2'd3, 7'h79, 1'b0);
    do_tick(); chk_disp("t2.w0", 2'd0, 7'h19, 1'b0);

    // 3. mid-frame load at idx 1
    do_tick(); chk_disp("t3.i1", 2'd1, 7'h30, 1'b0);
    do_load(16'hABCD);
    do_tick(); chk_disp("t3.i2", 2'd2, 7'h24, 1'b1);
    do_tick(); chk_disp("t3.i3", 2'd3, 7'h79, 1'b1);
    do_tick(); chk_disp("t3.i0", 2'd0, 7'h21, 1'b0);
    do_tick(); chk_disp("t3.i1n", 2'd1, 7'h46, 1'b0);

    // 4. load coinciding with wrap tick
    do_load(16'h9999);
    do_tick(); chk_disp("t4.i2", 2'd2, 7'h03, 1'b1);
    do_tick(); chk_disp("t4.i3", 2'd3, 7'h08, 1'b1);
    i_Scan_Clk = 1'b1;
    repeat (2) @(negedge i_Clk);       // tick is high in the coming cycle
    i_Digits = 16'h5555;
    i_Load   = 1'b1;
    @(negedge i_Clk);
    i_Load   = 1'b0;
    chk_disp("t4.w0", 2'd0, 7'h10, 1'b1);
    i_Scan_Clk = 1'b0;
    repeat (3) @(negedge i_Clk);
    do_tick(); chk_disp("t4.i1", 2'd1, 7'h10, 1'b1);
    do_tick(); chk_disp("t4.i2b", 2'd2, 7'h10, 1'b1);
    do_tick(); chk_disp("t4.i3b", 2'd3, 7'h10, 1'b1);
    do_tick(); chk_disp("t4.n0", 2'd0, 7'h12, 1'b0);

    // 5. long high phase: one advance only; fall does nothing
    i_Scan_Clk = 1'b1;
    repeat (100) @(negedge i_Clk);
    chk_disp("t5.hold", 2'd1, 7'h12, 1'b0);
    i_Scan_Clk = 1'b0;
    repeat (10) @(negedge i_Clk);
    chk_disp("t5.fall", 2'd1, 7'h12, 1'b0);

    // 6. leading zeros
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    lz7 = 7'h7F;
`else
    lz7 = 7'h40;
`endif
    do_load(16'h0070);
    do_tick(); do_tick();
    do_tick(); chk_disp("t6.i0", 2'd0, 7'h40, 1'b0);
    do_tick(); chk_disp("t6.i1", 2'd1, 7'h78, 1'b0);
    do_tick(); chk_disp("t6.i2", 2'd2, lz7, 1'b0);
    do_tick(); chk_disp("t6.i3", 2'd3, lz7, 1'b0);
    do_load(16'h0000);
    do_tick(); chk_disp("t6.z0", 2'd0, 7'h40, 1'b0);
    do_tick(); chk_disp("t6.z1", 2'd1, lz7, 1'b0);

    // 7. reset mid-frame with a pending load
    do_load(16'h8888);
    @(negedge i_Clk);
    Reset_n = 1'b0;
    #1;
    chk("t7.anode", {28'd0, o_Anode}, 32'hF);
    chk("t7.seg",   {25'd0, o_Seg},   32'h7F);
    chk("t7.pend",  {31'd0, o_Pending}, 32'h0);
    @(negedge i_Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge i_Clk);
    chk("t7.post", {28'd0, o_Anode}, 32'hF);
    do_tick(); chk_disp("t7.first", 2'd0, 7'h40, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
